// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: registered-ready pipeline stage with a one-entry skid buffer, flush and stall counter
module pipe_reg_skid #(
  parameter int DATA_W         = 84,
  parameter int CNT_W          = 16,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [1:0] occ_q, occ_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic in_xfer, out_xfer;
  always_comb begin
    in_xfer      = in_valid & in_ready_q;
    out_xfer     = main_valid_q & out_ready;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = CLEAR_ON_FLUSH ? '0 : main_data_q;
    end else if (out_xfer) begin
      // in_ready is low while skid is full, so skid and in_xfer never compete
      main_valid_d = skid_valid_q | in_xfer;
      main_data_d  = skid_valid_q ? skid_data_q : in_xfer ? in_data : main_data_q;
      skid_valid_d = 1'b0;
    end else if (in_xfer) begin
      main_valid_d = 1'b1;
      main_data_d  = main_valid_q ? main_data_q : in_data;
      skid_valid_d = main_valid_q;
      skid_data_d  = main_valid_q ? in_data : skid_data_q;
    end
    in_ready_d = ~skid_valid_d;
    occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    stall_d    = (main_valid_q & ~out_ready & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
      stall_q      <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
      stall_q      <= stall_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: random and directed checks of pipe_reg_skid against a FIFO-queue reference model
module tb_pipe_reg_skid;
  localparam int DATA_W = 84;
  localparam int CNT_W  = 4;
  localparam int SMAX   = (1 << CNT_W) - 1;
  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] stall_cnt;
  int n_tests = 0, n_fail = 0;
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_data = '0;
  int stall = 0;

  pipe_reg_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_data = '0;
    stall = 0;
  endtask

  // Stage is a FIFO of at most two payloads; the head is what out_data shows
  task automatic model_edge();
    int pre;
    bit outx, inx;
    if (!reset) return;
    pre  = q.size();
    outx = pre > 0 && out_ready;
    inx  = in_valid && pre < 2;
    if (pre > 0 && !out_ready && stall < SMAX) stall++;
    if (flush) begin
      q.delete();
      exp_data = '0;
    end else begin
      if (outx) void'(q.pop_front());
      if (inx) q.push_back(in_data);
      if (q.size() > 0) exp_data = q[0];
    end
  endtask

  task automatic check_all();
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_data", 128'(out_data), 128'(exp_data));
    chk("stall_cnt", 128'(stall_cnt), 128'(stall));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk) reset = 1'b1;
    // streaming
    drive(1'b1, 84'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("stream_data", 128'(out_data), 128'(k));
      chk("stream_ready", 128'(in_ready), 128'(1));
      in_data = DATA_W'(k + 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("stream_stall", 128'(stall_cnt), 128'(0));
    // backpressure into skid
    drive(1'b1, 84'hA, 1'b0, 1'b0);
    step();
    in_data = 84'hB;
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("bp_occ", 128'(occupancy), 128'(2));
    chk("bp_ready", 128'(in_ready), 128'(0));
    chk("bp_head", 128'(out_data), 128'(84'hA));
    out_ready = 1'b1;
    step();
    chk("bp_second", 128'(out_data), 128'(84'hB));
    chk("bp_ready_up", 128'(in_ready), 128'(1));
    step();
    // flush with full stage and a simultaneous input
    drive(1'b1, 84'hA, 1'b0, 1'b0);
    step();
    in_data = 84'hB;
    step();
    drive(1'b1, 84'hC, 1'b0, 1'b1);
    step();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_data", 128'(out_data), 128'(0));
    chk("flush_occ", 128'(occupancy), 128'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    chk("flush_no_c", 128'(out_valid), 128'(0));
    // async reset between edges with two entries held
    drive(1'b1, 84'h3, 1'b0, 1'b0);
    step();
    in_data = 84'h4;
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all();
    chk("arst_occ", 128'(occupancy), 128'(0));
    @(negedge clk) reset = 1'b1;
    drive(1'b1, 84'h5, 1'b1, 1'b0);
    step();
    chk("arst_lat_v", 128'(out_valid), 128'(1));
    chk("arst_lat_d", 128'(out_data), 128'(84'h5));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    // stall counter saturation
    drive(1'b1, 84'h7, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat", 128'(stall_cnt), 128'(15));
    // random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'({$urandom, $urandom, $urandom}),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
